bus_rr_arbiter: RTL and testbench



---
 rtl/bus_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one bus slave between N requesters (IDLE/BUSY/WAIT/FREE one-hot FSM).
// Latency: req seen in IDLE -> gnt on the next cycle; back-to-back grants are separated by one FREE cycle.
// Backpressure: grant is held until the slave signals done (plus any dly wait); optional watchdog via BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  input  logic           dly,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  // Bit positions inside the one-hot state register.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BBUSY = 2'd1,
    BWAIT = 2'd2,
    BFREE = 2'd3
  } state_idx_e;

  // Elaboration-time sanity checks on the configuration.
  if ((2 ** IDW) < N) begin : g_bad_idw
    $error("bus_rr_arbiter: IDW too narrow for N");
  end
  if ((2 ** TW) <= TIMEOUT) begin : g_bad_tw
    $error("bus_rr_arbiter: TW too narrow for TIMEOUT");
  end

  logic [3:0]     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           busy_q, busy_d;

  logic [2*N-1:0] req_sh;
  logic [IDW-1:0] arb_base;
  logic [IDW-1:0] arb_win;
  int             win_sum;
  logic           found;

  // Round-robin pick: first set req after arb_base, wrapping; FREE uses the owner as the new pointer.
  always_comb begin
    arb_base = state_q[BFREE] ? owner_q : ptr_q;
    req_sh   = {req, req} >> (int'(arb_base) + 1);
    win_sum  = 0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_sh[i]) begin
        found   = 1'b1;
        win_sum = int'(arb_base) + 1 + i;
      end
    end
    if (win_sum >= N) win_sum = win_sum - N;
    arb_win = IDW'(win_sum);
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // Next-state, owner/pointer update, optional watchdog and registered output decode.
  always_comb begin
    state_d = '0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (state_q[BBUSY]) begin
      if (!done)    state_d[BBUSY] = 1'b1;
      else if (dly) state_d[BWAIT] = 1'b1;
      else          state_d[BFREE] = 1'b1;
    end else if (state_q[BWAIT]) begin
      if (dly) state_d[BWAIT] = 1'b1;
      else     state_d[BFREE] = 1'b1;
    end else if (state_q[BFREE]) begin
      ptr_d = owner_q;
      if (|req) begin
        state_d[BBUSY] = 1'b1;
        owner_d        = arb_win;
      end else begin
        state_d[IDLE]  = 1'b1;
      end
    end else begin
      // IDLE, and also the recovery path should the register ever hold a non-one-hot value.
      if (|req) begin
        state_d[BBUSY] = 1'b1;
        owner_d        = arb_win;
      end else begin
        state_d[IDLE]  = 1'b1;
      end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q[BBUSY] || state_q[BWAIT]) begin
      cnt_d = cnt_q + 1'b1;
      // A normal exit on the expiry cycle wins; only a stuck transfer is aborted.
      if ((cnt_q == TW'(TIMEOUT - 1)) && !state_d[BFREE]) begin
        state_d        = '0;
        state_d[BFREE] = 1'b1;
        timeout_d      = 1'b1;
      end
    end
    if (state_d[BBUSY] && !state_q[BBUSY]) cnt_d = '0;
`endif

    busy_d = state_d[BBUSY] | state_d[BWAIT];
    gnt_d  = busy_d ? ({{(N-1){1'b0}}, 1'b1} << owner_d) : '0;
  end

  // State, arbitration and output registers; reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= 4'b0001;
      owner_q   <= '0;
      ptr_q     <= IDW'(N - 1);
      gnt_q     <= '0;
      busy_q    <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = owner_q;
  assign busy   = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter (N=4): reference model feeds an expected-output queue.
// Latency: each step drives inputs after a rising edge and checks the outputs one edge later.
// Backpressure: done/dly patterns exercise held grants, WAIT extension and reset mid-transfer.
module tb_bus_rr_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic         dly = 1'b0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;

  int checks = 0;
  int errs   = 0;

  // Reference model state: 0 idle, 1 busy, 2 wait, 3 free.
  int         m_state;
  logic [1:0] m_owner;
  logic [1:0] m_ptr;

  logic [7:0] exp_q[$];
  logic [N-1:0] gnt_hist[$];

  bus_rr_arbiter #(.N(N), .IDW(2), .TIMEOUT(64), .TW(7)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .dly(dly),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_arb(input logic [N-1:0] r, input logic [1:0] base);
    for (int i = 1; i <= N; i++) begin
      int j;
      j = (int'(base) + i) % N;
      if (r[j]) return j[1:0];
    end
    return base;
  endfunction

  task automatic m_reset();
    m_state = 0;
    m_owner = 2'd0;
    m_ptr   = 2'd3;
  endtask

  // Drive one cycle of inputs, predict the result, then compare after the edge.
  task automatic step(input logic [N-1:0] r, input logic d, input logic y);
    logic [N-1:0] eg;
    logic [7:0]   e, a;
    req = r; done = d; dly = y;
    case (m_state)
      0: if (|r) begin m_owner = m_arb(r, m_ptr); m_state = 1; end
      1: if (d) m_state = y ? 2 : 3;
      2: if (!y) m_state = 3;
      default: begin
        m_ptr = m_owner;
        if (|r) begin m_owner = m_arb(r, m_ptr); m_state = 1; end
        else m_state = 0;
      end
    endcase
    eg = (m_state == 1 || m_state == 2) ? (4'b0001 << m_owner) : 4'b0000;
    exp_q.push_back({eg, m_owner, (m_state == 1 || m_state == 2), 1'b0});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = {gnt, gnt_id, busy, timeout};
    chk("gnt", 32'(a[7:4]), 32'(e[7:4]));
    chk("gnt_id", 32'(a[3:2]), 32'(e[3:2]));
    chk("busy", 32'(a[1]), 32'(e[1]));
    chk("timeout", 32'(a[0]), 32'(e[0]));
    if (gnt != '0) gnt_hist.push_back(gnt);
  endtask

  initial begin
    int hi;
    logic [N-1:0] rot_exp[5];
    m_reset();

    // Reset with all requesting: nothing granted.
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst_n = 1'b1;

    // All requesting: strict rotation 0,1,2,3,0 with FREE gaps.
    step(4'b1111, 1'b1, 1'b0);
    chk("first_gnt", 32'(gnt), 32'h1);
    step(4'b1111, 1'b1, 1'b0);
    chk("free_gap", 32'(gnt), 0);
    repeat (7) step(4'b1111, 1'b1, 1'b0);
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("rot_len", 32'(gnt_hist.size()), 5);
    for (int i = 0; i < 5 && i < gnt_hist.size(); i++) chk("rot_order", 32'(gnt_hist[i]), 32'(rot_exp[i]));
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // Single requester, done late: six granted cycles, then re-grant.
    hi = 0;
    repeat (6) begin
      step(4'b0100, 1'b0, 1'b0);
      if (gnt == 4'b0100 && busy) hi++;
    end
    step(4'b0100, 1'b1, 1'b0);
    chk("hold_cycles", 32'(hi), 6);
    chk("hold_free", 32'(gnt), 0);
    step(4'b0100, 1'b0, 1'b0);
    chk("regrant", 32'(gnt), 32'h4);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // Owner drops req: grant persists until done.
    step(4'b0010, 1'b0, 1'b0);
    repeat (3) begin
      step(4'b0000, 1'b0, 1'b0);
      chk("drop_hold", 32'(gnt), 32'h2);
    end
    step(4'b0000, 1'b1, 1'b0);
    chk("drop_release", 32'(gnt), 0);
    step(4'b0000, 1'b0, 1'b0);

    // done with dly -> WAIT for three cycles; done inside WAIT ignored.
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("wait_hold", 32'(gnt), 32'h1);
    step(4'b0000, 1'b0, 1'b0);
    chk("wait_exit", 32'(gnt), 0);
    step(4'b0000, 1'b0, 1'b0);

    // Reset asserted in WAIT with requester 3 owning the bus.
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b1);
    chk("pre_rst_gnt", 32'(gnt), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 0);
    chk("async_rst_busy", 32'(busy), 0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1000, 1'b0, 1'b0);
    chk("post_rst_gnt", 32'(gnt), 32'h8);
    step(4'b0000, 1'b1, 1'b0);

    // Slave never finishes: grant held, no watchdog pulse.
    step(4'b0001, 1'b0, 1'b0);
    repeat (20) step(4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)));
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
